// File: rtl/count_arbiter_pkg.sv
// Shared types and constants for the count_arbiter round-robin burst sequencer.
package count_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic Req0 = 1'b0;
  localparam logic Req1 = 1'b1;

  function automatic logic [1:0] id_to_gnt(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/count_arbiter_up_counter.sv
// 2-bit wrapping up counter; advances on every edge where x is high.
module up_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] state
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= 2'd0;
    end else if (x) begin
      state <= state + 2'd1;
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter granting one of two requesters a burst of len steps on a
// shared 2-bit counter, then pulsing done.
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             x,
  output logic [1:0]       count,
  output logic             done,
  output logic             done_id
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             cur_q, cur_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             x_q, x_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;

  logic             win;
  logic [LEN_W-1:0] win_len;

  // On contention the requester not served last wins.
  assign win     = (req == 2'b11) ? ~last_q : (req[1] ? Req1 : Req0);
  assign win_len = win ? len1 : len0;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    last_d    = last_q;
    cur_d     = cur_q;
    gnt_d     = gnt_q;
    x_d       = 1'b0;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          cur_d = win;
          rem_d = win_len;
          gnt_d = id_to_gnt(win);
          if (win_len != '0) begin
            state_d = StRun;
            x_d     = 1'b1;
          end else begin
            state_d   = StDone;
            done_d    = 1'b1;
            done_id_d = win;
          end
        end
      end
      StRun: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d   = StDone;
          done_d    = 1'b1;
          done_id_d = cur_q;
        end else begin
          x_d = 1'b1;
        end
      end
      StDone: begin
        last_d  = cur_q;
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      last_q    <= Req1;
      cur_q     <= Req0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      x_q       <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      x_q       <= x_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  up_counter u_counter (
    .clk  (clk),
    .rst  (rst),
    .x    (x_q),
    .state(count)
  );

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign x       = x_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: timeline model plus directed scenarios and random traffic.
module tb_count_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] gnt;
  logic       busy, x, done, done_id;
  logic [1:0] count;

  always #5 clk = ~clk;

  count_arbiter #(.LEN_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .len0   (len0),
    .len1   (len1),
    .gnt    (gnt),
    .busy   (busy),
    .x      (x),
    .count  (count),
    .done   (done),
    .done_id(done_id)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a burst granted at edge k occupies cycles k+1..k+len+1,
  // with x on positions 1..len and done on position len+1.
  bit         m_act  = 1'b0;
  bit         m_id   = 1'b0;
  bit         m_last = 1'b1;
  int         m_len  = 0;
  int         m_pos  = 0;
  int         m_cnt  = 0;
  logic [1:0] e_gnt = 2'b00;
  logic [1:0] e_count = 2'b00;
  logic       e_busy = 1'b0, e_x = 1'b0, e_done = 1'b0, e_id = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_act = 1'b0; m_last = 1'b1; m_cnt = 0;
    end else begin
      if (e_x) m_cnt = (m_cnt + 1) % 4;
      if (m_act) begin
        if (m_pos == m_len + 1) begin
          m_act = 1'b0; m_last = m_id;
        end else begin
          m_pos++;
        end
      end else if (req != 2'b00) begin
        m_id  = (req == 2'b11) ? !m_last : req[1];
        m_len = m_id ? int'(len1) : int'(len0);
        m_act = 1'b1;
        m_pos = 1;
      end
    end
    e_gnt   = m_act ? (m_id ? 2'b10 : 2'b01) : 2'b00;
    e_busy  = m_act;
    e_x     = m_act && (m_pos <= m_len);
    e_done  = m_act && (m_pos == m_len + 1);
    e_id    = m_id;
    e_count = 2'(m_cnt);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("busy", 32'(busy), 32'(e_busy));
      check("x", 32'(x), 32'(e_x));
      check("done", 32'(done), 32'(e_done));
      check("count", 32'(count), 32'(e_count));
      if (e_done) check("done_id", 32'(done_id), 32'(e_id));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // Drives one burst from IDLE; positions are counted from the first gnt cycle (=1).
  task automatic burst(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                       input int drop_at, input bit rel, output int xs, output int dpos,
                       output logic did, output logic [1:0] cnt, output logic [1:0] g);
    int  gc;
    bit  seen;
    req = r; len0 = l0; len1 = l1;
    xs = 0; dpos = 0; did = 1'b0; cnt = 2'b00; g = 2'b00; gc = 0; seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (g == 2'b00 && gnt != 2'b00) begin g = gnt; gc = i; end
      if (x) xs++;
      if (g != 2'b00 && (i - gc + 1) == drop_at) req = 2'b00;
      if (done) begin
        dpos = i - gc + 1; did = done_id; cnt = count; seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (rel) req = 2'b00;
  endtask

  int         xs, dpos;
  logic       did;
  logic [1:0] cnt, g, cnt0;
  bit         saw_done;

  initial begin
    rst = 1'b0; req = 2'b11; len0 = 4'd1; len1 = 4'd1;

    // Reset held with both requests asserted.
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_count", 32'(count), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("first_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    wait_idle();

    // Single burst of 5 from count 0.
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    burst(2'b01, 4'd5, 4'd0, 0, 1'b1, xs, dpos, did, cnt, g);
    check("single_x", 32'(xs), 32'd5);
    check("single_dpos", 32'(dpos), 32'd6);
    check("single_id", 32'(did), 32'd0);
    check("single_cnt", 32'(cnt), 32'd1);
    wait_idle();

    // Contention: grants alternate 0,1,0,1 from a fresh reset.
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    burst(2'b11, 4'd2, 4'd3, 0, 1'b0, xs, dpos, did, cnt, g);
    check("rr0_id", 32'(did), 32'd0); check("rr0_cnt", 32'(cnt), 32'd2);
    burst(2'b11, 4'd2, 4'd3, 0, 1'b0, xs, dpos, did, cnt, g);
    check("rr1_id", 32'(did), 32'd1); check("rr1_cnt", 32'(cnt), 32'd1);
    burst(2'b11, 4'd2, 4'd3, 0, 1'b0, xs, dpos, did, cnt, g);
    check("rr2_id", 32'(did), 32'd0); check("rr2_cnt", 32'(cnt), 32'd3);
    burst(2'b11, 4'd2, 4'd3, 0, 1'b1, xs, dpos, did, cnt, g);
    check("rr3_id", 32'(did), 32'd1); check("rr3_cnt", 32'(cnt), 32'd2);
    check("rr3_gnt", 32'(g), 32'd2);
    wait_idle();

    // Zero-length burst: grant and done in the same cycle, no x.
    cnt0 = count;
    burst(2'b10, 4'd7, 4'd0, 0, 1'b1, xs, dpos, did, cnt, g);
    check("zero_x", 32'(xs), 32'd0);
    check("zero_dpos", 32'(dpos), 32'd1);
    check("zero_gnt", 32'(g), 32'd2);
    check("zero_cnt", 32'(cnt), 32'(cnt0));
    wait_idle();

    // Request dropped mid-burst still completes.
    burst(2'b10, 4'd0, 4'd4, 2, 1'b1, xs, dpos, did, cnt, g);
    check("drop_x", 32'(xs), 32'd4);
    check("drop_dpos", 32'(dpos), 32'd5);
    check("drop_id", 32'(did), 32'd1);
    wait_idle();

    // Reset after three x pulses of a length-8 burst.
    req = 2'b01; len0 = 4'd8; xs = 0; saw_done = 1'b0;
    for (int i = 0; i < 20 && xs < 3; i++) begin
      @(negedge clk);
      if (x) xs++;
      if (done) saw_done = 1'b1;
    end
    check("abort_pulses", 32'(xs), 32'd3);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_done", 32'(done | saw_done), 32'd0);
    rst = 1'b1; req = 2'b11; len0 = 4'd1;
    @(negedge clk);
    check("abort_regnt", 32'(gnt), 32'd1);
    req = 2'b00;
    wait_idle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 149) != 0);
      req  = 2'($urandom);
      len0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      len1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
    end
    rst = 1'b1; req = 2'b00;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
